// File: rtl/rsa_uart_pkg.sv
// Shared types and sizing helpers for the RSA UART frame receiver.
// Defaults correspond to 50 MHz / 9600 baud with three 32-bit operands.
package rsa_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int DEF_CLK_HZ       = 50000000;
    localparam int DEF_BAUD         = 9600;
    localparam int DEF_OP_W         = 32;
    localparam int DEF_NUM_OPS      = 3;
    localparam int DEF_TIMEOUT_BITS = 20;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int nbytes(input int op_w, input int num_ops);
        return op_w * num_ops / 8;
    endfunction

    localparam int CLKS_PER_BIT = clks_per_bit(DEF_CLK_HZ, DEF_BAUD);
    localparam int NBYTES       = nbytes(DEF_OP_W, DEF_NUM_OPS);
    localparam int BYTE_CNT_W   = $clog2(NBYTES + 1);
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, bit-timing FSM and optional even parity.
// Build option: define RX_PARITY_EN to insert a parity bit between data and stop.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a falling edge on rxs
// ST_START     | half a bit-time into the start bit, confirm it is still low
// ST_DATA      | sampling 8 data bits, LSB first
// ST_PARITY    | sampling the even-parity bit (RX_PARITY_EN only)
// ST_STOP      | sampling the stop bit, deliver or reject the byte
// ST_WAIT_HIGH | after a bad stop bit, wait for the line to return high
module uart_rx_byte import rsa_uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_err,
    output logic       busy,
    output logic       start_edge
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t   state, state_nxt;
    logic        rx_meta, rxs, rxs_d;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        par_err, par_err_nxt;
    logic        tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            par_err <= par_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        par_err_nxt = par_err;
        byte_valid  = 1'b0;
        framing_err = 1'b0;
        start_edge  = rxs_d & ~rxs;
        tick        = (cnt == '0);
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_nxt = ST_START;
                    cnt_nxt   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!rxs) begin
                    state_nxt   = ST_DATA;
                    cnt_nxt     = FULL_LOAD;
                    bit_idx_nxt = '0;
                    par_err_nxt = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    shreg_nxt   = {rxs, shreg[7:1]};
                    cnt_nxt     = FULL_LOAD;
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    cnt_nxt   = FULL_LOAD;
                    state_nxt = ST_STOP;
                    // even parity: the parity bit equals the XOR of the data bits
                    if (rxs != ^shreg) begin
                        framing_err = 1'b1;
                        par_err_nxt = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rxs) begin
                    state_nxt  = ST_IDLE;
                    byte_valid = ~par_err;
                end else begin
                    state_nxt   = ST_WAIT_HIGH;
                    framing_err = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign byte_data = shreg;
    assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/rsa_uart_frame_rx.sv
// UART frame loader for the RSA core: packs NUM_OPS operands into one frame with
// a one-frame output buffer, overrun and idle-timeout recovery. Option: RX_PARITY_EN.
module rsa_uart_frame_rx import rsa_uart_pkg::*; #(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int BAUD         = DEF_BAUD,
    parameter int OP_W         = DEF_OP_W,
    parameter int NUM_OPS      = DEF_NUM_OPS,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rx,
    output logic [OP_W*NUM_OPS-1:0]             frame_data,
    output logic                                frame_valid,
    input  logic                                frame_ready,
    output logic [$clog2(OP_W*NUM_OPS/8+1)-1:0] byte_count,
    output logic                                busy,
    output logic                                framing_err,
    output logic                                overrun,
    output logic                                timeout
);

    localparam int CPB     = clks_per_bit(CLK_HZ, BAUD);
    localparam int NB      = nbytes(OP_W, NUM_OPS);
    localparam int FW      = OP_W * NUM_OPS;
    localparam int BCW     = $clog2(NB + 1);
    localparam int TO_CLKS = TIMEOUT_BITS * CPB;
    localparam int TW      = $clog2(TO_CLKS + 1);
    localparam logic [BCW-1:0] FULL_COUNT = BCW'(NB);
    localparam logic [TW-1:0]  TO_LOAD    = TW'(TO_CLKS - 1);

    logic [7:0]     byte_data;
    logic           byte_valid, rx_ferr, start_edge;
    logic [FW-1:0]  asm_q, asm_nxt;
    logic [BCW-1:0] count_nxt, wr_idx;
    logic [TW-1:0]  to_cnt, to_cnt_nxt;
    logic           full, consume, move, accept, to_run, to_fire;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx_byte (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .framing_err (rx_ferr),
        .busy        (busy),
        .start_edge  (start_edge)
    );

    always_comb begin
        full    = (byte_count == FULL_COUNT);
        consume = frame_valid & frame_ready;
        move    = full & (~frame_valid | consume);
        // a byte arriving on the transfer edge lands in slot 0 of the freed register
        accept  = byte_valid & (~full | move);
        wr_idx  = move ? '0 : byte_count;
        to_run  = (byte_count != '0) & ~full & ~busy & ~start_edge;
        to_fire = to_run & (to_cnt == '0);

        asm_nxt = asm_q;
        if (accept) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_idx == BCW'(i)) asm_nxt[8*i +: 8] = byte_data;
            end
        end

        count_nxt = byte_count;
        if (move || to_fire) count_nxt = '0;
        if (accept)          count_nxt = wr_idx + 1'b1;

        to_cnt_nxt = (!to_run || to_fire) ? TO_LOAD : to_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q       <= '0;
            byte_count  <= '0;
            to_cnt      <= TO_LOAD;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            asm_q       <= asm_nxt;
            byte_count  <= count_nxt;
            to_cnt      <= to_cnt_nxt;
            framing_err <= rx_ferr;
            overrun     <= byte_valid & full & ~move;
            timeout     <= to_fire;
            if (move) begin
                frame_data  <= asm_q;
                frame_valid <= 1'b1;
            end else if (consume) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rsa_uart_frame_rx.sv
// Self-checking bench for rsa_uart_frame_rx with a shortened bit time (16 clocks/bit).
module tb_rsa_uart_frame_rx;

    localparam int CLK_HZ = 160;
    localparam int BAUD = 10;
    localparam int OP_W = 32;
    localparam int NUM_OPS = 3;
    localparam int TIMEOUT_BITS = 20;
    localparam int CPB = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int NB = OP_W * NUM_OPS / 8;
    localparam int FW = OP_W * NUM_OPS;
    localparam int BCW = $clog2(NB + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic frame_ready = 1'b0;
    logic [FW-1:0] frame_data;
    logic frame_valid;
    logic [BCW-1:0] byte_count;
    logic busy, framing_err, overrun, timeout;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0, fe_n = 0, ov_n = 0, to_n = 0;
    logic [FW-1:0] got_q[$];
    int hs_cyc[$];
    logic prev_valid = 1'b0, prev_hs = 1'b0;
    logic [FW-1:0] prev_data = '0;

    rsa_uart_frame_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OP_W(OP_W), .NUM_OPS(NUM_OPS), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .byte_count(byte_count), .busy(busy),
        .framing_err(framing_err), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Observer: pulse counts, delivered frames, and frame_data stability while held.
    always @(negedge clk) begin
        cyc++;
        if (framing_err) fe_n++;
        if (overrun) ov_n++;
        if (timeout) to_n++;
        if (!reset && prev_valid && !prev_hs && frame_valid) begin
            tests_run++;
            if (frame_data !== prev_data) begin
                tests_failed++;
                $display("FAIL frame_stable: frame_data %h, required %h", frame_data, prev_data);
            end
        end
        if (frame_valid && frame_ready) begin
            got_q.push_back(frame_data);
            hs_cyc.push_back(cyc);
        end
        prev_valid = frame_valid;
        prev_hs = frame_valid && frame_ready;
        prev_data = frame_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_v);
    endtask

    task automatic send_random_frame(output logic [FW-1:0] f, input int max_gap);
        logic [7:0] b;
        f = '0;
        for (int k = 0; k < NB; k++) begin
            b = 8'($urandom);
            f[8*k +: 8] = b;
            send_byte(b, 1'b1);
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 frame_ready = v;
    endtask

    task automatic wait_frames(input int k, input int limit);
        int n = 0;
        while (got_q.size() < k && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        frame_ready = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", frame_valid); end
        tests_run++;
        if (frame_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h, required 0", frame_data); end
        tests_run++;
        if (byte_count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d, required 0", byte_count); end
        tests_run++;
        if ({busy, framing_err, overrun, timeout} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, required 0000", {busy, framing_err, overrun, timeout});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] bytes [NB] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h5D, 8'h36,
                                   8'h15, 8'h73, 8'hED, 8'h04, 8'h8A, 8'h00};
        logic [FW-1:0] exp_f = 96'h008A04ED_7315365D_00010001;
        int fe0 = fe_n;
        got_q.delete();
        hs_cyc.delete();
        set_ready(1'b1);
        for (int k = 0; k < NB; k++) send_byte(bytes[k], 1'b1);
        wait_frames(1, 4 * CPB);
        repeat (2 * CPB) @(negedge clk);
        tests_run++;
        if (got_q.size() != 1) begin tests_failed++; $display("FAIL basic_count: got %0d frames, required 1", got_q.size()); end
        tests_run++;
        if (got_q.size() < 1 || got_q[0] !== exp_f) begin
            tests_failed++;
            $display("FAIL basic_data: got %h, required %h", (got_q.size() > 0) ? got_q[0] : '0, exp_f);
        end
        tests_run++;
        if (byte_count !== '0 || frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle: count %0d valid %b, required 0 0", byte_count, frame_valid);
        end
        tests_run++;
        if (fe_n != fe0) begin tests_failed++; $display("FAIL basic_ferr: got %0d pulses, required 0", fe_n - fe0); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] fa, fb;
        int ov0;
        got_q.delete();
        hs_cyc.delete();
        set_ready(1'b0);
        send_random_frame(fa, 4);
        fb = '0;
        for (int k = 0; k < NB; k++) begin
            fb[8*k +: 8] = 8'hFF;
            send_byte(8'hFF, 1'b1);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_data !== fa) begin
            tests_failed++;
            $display("FAIL hold_first: valid %b data %h, required 1 %h", frame_valid, frame_data, fa);
        end
        tests_run++;
        if (byte_count !== BCW'(NB)) begin tests_failed++; $display("FAIL hold_second_count: got %0d, required %0d", byte_count, NB); end
        ov0 = ov_n;
        send_byte(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (ov_n != ov0 + 1) begin tests_failed++; $display("FAIL overrun_pulse: got %0d pulses, required 1", ov_n - ov0); end
        tests_run++;
        if (byte_count !== BCW'(NB) || frame_data !== fa) begin
            tests_failed++;
            $display("FAIL overrun_keep: count %0d data %h, required %0d %h", byte_count, frame_data, NB, fa);
        end
        set_ready(1'b1);
        wait_frames(2, 10);
        @(negedge clk);
        tests_run++;
        if (got_q.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d frames, required 2", got_q.size()); end
        tests_run++;
        if (got_q.size() < 2 || got_q[0] !== fa || got_q[1] !== fb) begin
            tests_failed++;
            $display("FAIL b2b_order: first %h second %h, required %h %h",
                     (got_q.size() > 0) ? got_q[0] : '0, (got_q.size() > 1) ? got_q[1] : '0, fa, fb);
        end
        tests_run++;
        if (hs_cyc.size() < 2 || hs_cyc[1] - hs_cyc[0] != 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got %0d cycles, required 1", (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1);
        end
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drop: valid %b, required 0", frame_valid); end
    endtask

    task automatic test_framing();
        int fe0 = fe_n;
        send_byte(8'hA5, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        tests_run++;
        if (fe_n != fe0 + 1) begin tests_failed++; $display("FAIL ferr_pulse: got %0d pulses, required 1", fe_n - fe0); end
        tests_run++;
        if (byte_count !== '0) begin tests_failed++; $display("FAIL ferr_count: got %0d, required 0", byte_count); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL ferr_wait_high: busy %b, required 1", busy); end
        rx = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || byte_count !== '0) begin
            tests_failed++;
            $display("FAIL ferr_recover: busy %b count %0d, required 0 0", busy, byte_count);
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b = 8'h3C;
        int fe0 = fe_n;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~(^b));
        drive_bit(1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (fe_n != fe0 + 1) begin tests_failed++; $display("FAIL parity_pulse: got %0d pulses, required 1", fe_n - fe0); end
        tests_run++;
        if (byte_count !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_drop: count %0d busy %b, required 0 0", byte_count, busy);
        end
    endtask
`endif

    task automatic test_glitch();
        int fe0 = fe_n;
        int n = 0;
        int dur = 0;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_start: busy %b, required 1", busy); end
        while (busy && dur < 4 * CPB) begin @(negedge clk); dur++; end
        tests_run++;
        if (dur > CPB / 2 + 3) begin tests_failed++; $display("FAIL glitch_busy_len: got %0d cycles, required <= %0d", dur, CPB / 2 + 3); end
        tests_run++;
        if (byte_count !== '0 || fe_n != fe0) begin
            tests_failed++;
            $display("FAIL glitch_no_byte: count %0d ferr %0d, required 0 0", byte_count, fe_n - fe0);
        end
    endtask

    task automatic test_timeout();
        logic [FW-1:0] f;
        int to0 = to_n;
        int n = 0;
        got_q.delete();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1);
        tests_run++;
        if (byte_count !== BCW'(5)) begin tests_failed++; $display("FAIL timeout_partial: got %0d, required 5", byte_count); end
        repeat (19 * CPB) @(negedge clk);
        tests_run++;
        if (to_n != to0) begin tests_failed++; $display("FAIL timeout_early: got %0d pulses, required 0", to_n - to0); end
        while (to_n == to0 && n < 3 * CPB) begin @(negedge clk); n++; end
        @(negedge clk);
        tests_run++;
        if (to_n != to0 + 1) begin tests_failed++; $display("FAIL timeout_pulse: got %0d pulses, required 1", to_n - to0); end
        tests_run++;
        if (byte_count !== '0) begin tests_failed++; $display("FAIL timeout_clear: got %0d, required 0", byte_count); end
        send_random_frame(f, 3);
        wait_frames(1, 4 * CPB);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== f) begin
            tests_failed++;
            $display("FAIL timeout_next_frame: got %h (%0d frames), required %h", (got_q.size() > 0) ? got_q[0] : '0, got_q.size(), f);
        end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] f;
        logic [7:0] b;
        int fe0, ov0, to0;
        set_ready(1'b0);
        send_random_frame(f, 2);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 1'b1);
        b = 8'($urandom);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        fe0 = fe_n; ov0 = ov_n; to0 = to_n;
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (frame_valid !== 1'b0 || frame_data !== '0 || byte_count !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_state: valid %b data %h count %0d busy %b, required all 0",
                     frame_valid, frame_data, byte_count, busy);
        end
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        tests_run++;
        if (fe_n != fe0 || ov_n != ov0 || to_n != to0) begin
            tests_failed++;
            $display("FAIL midreset_pulses: ferr %0d ovr %0d tmo %0d, required 0 0 0", fe_n - fe0, ov_n - ov0, to_n - to0);
        end
        got_q.delete();
        set_ready(1'b1);
        send_random_frame(f, 2);
        wait_frames(1, 4 * CPB);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== f) begin
            tests_failed++;
            $display("FAIL midreset_next_frame: got %h (%0d frames), required %h", (got_q.size() > 0) ? got_q[0] : '0, got_q.size(), f);
        end
    endtask

    task automatic test_random_frames();
        logic [FW-1:0] exp_q[$];
        logic [FW-1:0] f;
        got_q.delete();
        set_ready(1'b1);
        for (int j = 0; j < 3; j++) begin
            send_random_frame(f, 3 * CPB);
            exp_q.push_back(f);
        end
        wait_frames(3, 4 * CPB);
        tests_run++;
        if (got_q.size() != 3) begin tests_failed++; $display("FAIL random_count: got %0d frames, required 3", got_q.size()); end
        for (int j = 0; j < 3; j++) begin
            tests_run++;
            if (got_q.size() <= j || got_q[j] !== exp_q[j]) begin
                tests_failed++;
                $display("FAIL random_frame%0d: got %h, required %h", j, (got_q.size() > j) ? got_q[j] : '0, exp_q[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_framing();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
